divider_4bit: RTL and testbench

Sequential unsigned restoring divider for 4-bit operands. It computes quotient and remainder with one shift-and-subtract iteration per clock. Each subtract uses the same two's-complement convention as the team's 4-bit arithmetic circuit (subtract mode, carry-out = 1 means no borrow). It is the inverse companion to the combinational add/subtract path: it sits beside that datapath and gives a multi-cycle division result through a start/done handshake.

---
 rtl/divider_4bit.sv | 101 ++++++++++
 tb/tb_divider_4bit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_4bit.sv
// rtl/divider_4bit.sv - sequential unsigned restoring divider with a start/done handshake
// One shift-and-subtract per clock; a zero divisor completes in a single cycle.
module divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH+1:0] sum;
  logic             carry;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // Subtract as T + ~{0,divisor} + 1; carry-out set means no borrow (T >= divisor).
  always_comb begin
    t      = {r[WIDTH-1:0], q[WIDTH-1]};
    sum    = {1'b0, t} + {1'b0, ~{1'b0, dsr}} + (WIDTH+2)'(1);
    carry  = sum[WIDTH+1];
    r_next = carry ? sum[WIDTH:0] : t;
    q_next = {q[WIDTH-2:0], carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dsr         <= '0;
      q           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dsr         <= divisor;
            q           <= dividend;
            r           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_4bit.sv
// tb/tb_divider_4bit.sv - self-checking bench for divider_4bit
// Directed vector table, multi-cycle corner sequences and an exhaustive operand sweep.
module tb_divider_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  divider_4bit #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         busyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busyc);
    bit ok;
    lat = 0;
    busyc = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1;
        break;
      end
      if (busy) busyc++;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int busyc;
    int seen;

    vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5, 4};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4};
    vecs[2] = '{4'd2,  4'd9, 4'd0,  4'd2, 1'b0, 5, 4};
    vecs[3] = '{4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 1, 0};
    vecs[4] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 5, 4};
    vecs[5] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, 4};
    vecs[6] = '{4'd8,  4'd3, 4'd2,  4'd2, 1'b0, 5, 4};
    vecs[7] = '{4'd0,  4'd0, 4'hF,  4'd0, 1'b1, 1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);

    // Directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat, busyc);
      check($sformatf("v%0d_quotient", i), int'(quotient), int'(vecs[i].q));
      check($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
      check($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), busyc, vecs[i].busyc);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_quotient_held", i), int'(quotient), int'(vecs[i].q));
    end

    // Start and operand changes during RUN are ignored
    start_op(4'd9, 4'd2);
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd15;
    divisor = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 4'd3;
    divisor = 4'd3;
    wait_done(lat, busyc);
    check("midrun_quotient", int'(quotient), 4);
    check("midrun_remainder", int'(remainder), 1);
    check("midrun_latency", lat, 4);

    // Back-to-back start in the done cycle
    start_op(4'd14, 4'd4);
    @(negedge clk);
    check("b2b_busy", int'(busy), 1);
    check("b2b_quotient_held", int'(quotient), 4);
    wait_done(lat, busyc);
    check("b2b_quotient", int'(quotient), 3);
    check("b2b_remainder", int'(remainder), 2);
    check("b2b_latency", lat + 1, 5);

    // Reset in the 2nd RUN cycle aborts without a done pulse
    @(negedge clk);
    start_op(4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);
    start_op(4'd12, 4'd5);
    wait_done(lat, busyc);
    check("after_abort_quotient", int'(quotient), 2);
    check("after_abort_remainder", int'(remainder), 2);

    // rst and start in the same cycle: rst wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    dividend = 4'd6;
    divisor = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(busy), 0);
    check("rst_start_quotient", int'(quotient), 0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done(lat, busyc);
        if (b != 0) begin
          check($sformatf("ex_%0d_%0d_identity", a, b), int'(quotient) * b + int'(remainder), a);
          check($sformatf("ex_%0d_%0d_rem_lt", a, b), int'(int'(remainder) < b), 1);
          check($sformatf("ex_%0d_%0d_quotient", a, b), int'(quotient), a / b);
        end else begin
          check($sformatf("ex_%0d_dbz", a), int'(div_by_zero), 1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
